modulo_datapath: RTL and testbench

MODULO_DATAPATH -- requirements
Module: modulo_datapath

---
 rtl/modulo_datapath_pkg.sv | 11 +
 rtl/modulo_alu.sv | 26 ++
 rtl/modulo_datapath.sv | 110 +++++++++++
 tb/tb_modulo_datapath.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/modulo_datapath_pkg.sv
// Shared definitions for the modulo datapath and its controller.
package modulo_datapath_pkg;

  // ALU operation select. Any encoding outside these three behaves as idle.
  typedef enum logic [2:0] {
    ALU_COMPARE = 3'd0,
    ALU_DIFF    = 3'd1,
    ALU_IDLE    = 3'd2
  } alu_mode_e;

endpackage

// File: rtl/modulo_alu.sv
// Combinational ALU for the repeated-subtraction modulo loop.
module modulo_alu
  import modulo_datapath_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   mode,
  output logic [W-1:0] res,
  output logic         flag
);

  // Compare raises flag when a < b (unsigned); diff wraps modulo 2^W; idle drives zeros.
  always_comb begin
    // NOTE: defaults assigned first so every path drives every output and no latch is inferred.
    res  = '0;
    flag = 1'b0;
    case (mode)
      ALU_COMPARE: flag = (a < b);
      ALU_DIFF:    res  = a - b;
      default:     ;
    endcase
  end

endmodule

// File: rtl/modulo_datapath.sv
// Datapath for a modulo unit: operand registers, working register erg, termination
// flag and result/valid/error outputs, driven by strobes from an external controller.
module modulo_datapath
  import modulo_datapath_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   alu_mode_i,
  input  logic         wren_update_Zahlen_i,
  input  logic         wren_Zahl1_to_erg_i,
  input  logic         wren_res_to_erg_i,
  input  logic         wren_term_erg_i,
  input  logic         erg_to_alu_a_i,
  input  logic         Zahl2_to_alu_b_i,
  input  logic         check_for_termination_i,
  output logic [W-1:0] result_o,
  output logic         valid_o,
  output logic         err_o
);

  logic [W-1:0] zahl1;
  logic [W-1:0] zahl2;
  logic [W-1:0] erg;
  logic         term;
  logic         done;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_res;
  logic         alu_flag;

  logic         erg_from_zahl1;
  logic         erg_from_res;
  logic         term_we;
  logic         check_fire;
  logic         divide_by_zero;

  // Operand selects: a deasserted select feeds zero into the ALU.
  assign alu_a = erg_to_alu_a_i   ? erg   : '0;
  assign alu_b = Zahl2_to_alu_b_i ? zahl2 : '0;

  modulo_alu #(.W(W)) u_alu (
    .a    (alu_a),
    .b    (alu_b),
    .mode (alu_mode_i),
    .res  (alu_res),
    .flag (alu_flag)
  );

  // Done gating: once the result is out, late erg/term strobes and further checks are
  // ignored, since the controller only sees valid one cycle late. Zahl1 load beats res load.
  always_comb begin
    divide_by_zero = (zahl2 == '0);
    erg_from_zahl1 = wren_Zahl1_to_erg_i && !done;
    erg_from_res   = wren_res_to_erg_i && !wren_Zahl1_to_erg_i && !done;
    term_we        = wren_term_erg_i && !done;
    check_fire     = check_for_termination_i && !done && !wren_update_Zahlen_i
                     && (term || divide_by_zero);
  end

  // All state: operand capture, erg/term updates, completion with one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      zahl1    <= '0;
      zahl2    <= '0;
      erg      <= '0;
      term     <= 1'b0;
      done     <= 1'b0;
      result_o <= '0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      valid_o <= 1'b0;

      if (wren_update_Zahlen_i) begin
        zahl1 <= a_i;
        zahl2 <= b_i;
        done  <= 1'b0;
        err_o <= 1'b0;
      end

      if (erg_from_zahl1) begin
        erg <= zahl1;
      end else if (erg_from_res) begin
        erg <= alu_res;
      end

      if (term_we) begin
        term <= alu_flag;
      end

      if (check_fire) begin
        done    <= 1'b1;
        valid_o <= 1'b1;
        if (divide_by_zero) begin
          err_o    <= 1'b1;
          result_o <= '0;
        end else begin
          result_o <= erg;
        end
      end
    end
  end

endmodule

// File: tb/tb_modulo_datapath.sv
// Bench for modulo_datapath: emulates the controller strobe sequence, keeps a scoreboard
// of expected results pushed at each update and popped on every valid_o pulse.
module tb_modulo_datapath;
  import modulo_datapath_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [2:0]   alu_mode_i;
  logic         wren_update_Zahlen_i;
  logic         wren_Zahl1_to_erg_i;
  logic         wren_res_to_erg_i;
  logic         wren_term_erg_i;
  logic         erg_to_alu_a_i;
  logic         Zahl2_to_alu_b_i;
  logic         check_for_termination_i;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic         err_o;

  typedef struct {
    logic [W-1:0] result;
    logic         err;
    int           latency;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   upd_cyc  = 0;
  int   pulses   = 0;

  modulo_datapath #(.W(W)) dut (
    .clk                     (clk),
    .rst_i                   (rst_i),
    .a_i                     (a_i),
    .b_i                     (b_i),
    .alu_mode_i              (alu_mode_i),
    .wren_update_Zahlen_i    (wren_update_Zahlen_i),
    .wren_Zahl1_to_erg_i     (wren_Zahl1_to_erg_i),
    .wren_res_to_erg_i       (wren_res_to_erg_i),
    .wren_term_erg_i         (wren_term_erg_i),
    .erg_to_alu_a_i          (erg_to_alu_a_i),
    .Zahl2_to_alu_b_i        (Zahl2_to_alu_b_i),
    .check_for_termination_i (check_for_termination_i),
    .result_o                (result_o),
    .valid_o                 (valid_o),
    .err_o                   (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controller strobes (from a negedge), then sample at the next negedge.
  task automatic cycle(input logic [2:0] mode, input logic asel, input logic bsel,
                       input logic upd, input logic z1, input logic res,
                       input logic trm, input logic chk);
    exp_t e;
    alu_mode_i              = mode;
    erg_to_alu_a_i          = asel;
    Zahl2_to_alu_b_i        = bsel;
    wren_update_Zahlen_i    = upd;
    wren_Zahl1_to_erg_i     = z1;
    wren_res_to_erg_i       = res;
    wren_term_erg_i         = trm;
    check_for_termination_i = chk;
    @(negedge clk);
    cyc++;
    if (valid_o) begin
      pulses++;
      if (sb.size() == 0) begin
        check("valid_without_expectation", 32'(valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("result_o", 32'(result_o), 32'(e.result));
        check("err_o", 32'(err_o), 32'(e.err));
        check("latency", 32'(cyc - upd_cyc), 32'(e.latency));
      end
    end
  endtask

  task automatic idle_cycle();
    cycle(ALU_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Controller emulation: update, load erg, then compare/check/diff/3 idle per iteration.
  // The diff+write after the check is issued even when valid arrives, as a controller
  // with a registered valid input would.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    int           q;
    logic [W-1:0] erg_exp;
    bit           seen;
    q         = (b == 0) ? 0 : int'(a) / int'(b);
    e.result  = (b == 0) ? '0 : a % b;
    e.err     = (b == 0);
    e.latency = 6 * q + 4;
    erg_exp   = (b == 0) ? a : a % b;
    pulses    = 0;
    a_i       = a;
    b_i       = b;
    upd_cyc   = cyc;
    sb.push_back(e);
    cycle(ALU_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Zahl1 load and res load together: Zahl1 must win.
    cycle(ALU_DIFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("erg_load_priority", 32'(dut.erg), 32'(a));
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      cycle(ALU_COMPARE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(ALU_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      seen = (pulses != 0);
      cycle(ALU_DIFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (!seen) begin
        repeat (3) idle_cycle();
      end
    end
    check("erg_after_post_valid_write", 32'(dut.erg), 32'(erg_exp));
    // A further term write plus check must not produce a second pulse.
    cycle(ALU_COMPARE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycle();
    check("single_valid_pulse", 32'(pulses), 32'd1);
    check("result_held", 32'(result_o), 32'(e.result));
    sb.delete();
  endtask

  initial begin
    rst_i                   = 1'b1;
    a_i                     = '0;
    b_i                     = '0;
    alu_mode_i              = ALU_IDLE;
    wren_update_Zahlen_i    = 1'b0;
    wren_Zahl1_to_erg_i     = 1'b0;
    wren_res_to_erg_i       = 1'b0;
    wren_term_erg_i         = 1'b0;
    erg_to_alu_a_i          = 1'b0;
    Zahl2_to_alu_b_i        = 1'b0;
    check_for_termination_i = 1'b0;

    #12;
    check("reset_result_o", 32'(result_o), 32'd0);
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_err_o", 32'(err_o), 32'd0);
    check("reset_erg", 32'(dut.erg), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // 17 mod 5 = 2, valid 22 cycles after the update strobe.
    run_op(8'd17, 8'd5);
    // a < b terminates at the first check with no diff write.
    run_op(8'd3, 8'd7);

    // Abort 17 mod 5 mid-loop with an asynchronous reset.
    pulses  = 0;
    a_i     = 8'd17;
    b_i     = 8'd5;
    upd_cyc = cyc;
    cycle(ALU_IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(ALU_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      cycle(ALU_COMPARE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle(ALU_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cycle(ALU_DIFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) idle_cycle();
    end
    check("pre_reset_erg", 32'(dut.erg), 32'd7);
    check("pre_reset_result_held", 32'(result_o), 32'd3);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_reset_result_o", 32'(result_o), 32'd0);
    check("async_reset_err_o", 32'(err_o), 32'd0);
    check("async_reset_valid_o", 32'(valid_o), 32'd0);
    check("async_reset_erg", 32'(dut.erg), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    sb.delete();
    repeat (6) idle_cycle();
    check("no_valid_after_abort", 32'(pulses), 32'd0);

    run_op(8'd9, 8'd4);
    // Exact multiple: remainder 0, erg must survive the post-valid diff write.
    run_op(8'd10, 8'd5);
    // Divide by zero: error flag, zero result, single pulse.
    run_op(8'd200, 8'd0);
    repeat (4) idle_cycle();
    check("err_held", 32'(err_o), 32'd1);
    // Largest loop count for W=8; err must clear on the new update.
    run_op(8'd255, 8'd1);
    check("err_cleared_by_update", 32'(err_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
